// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register with operand forwarding and
// load-use hazard detection for a small five-stage RISC pipeline.
//
// The stage captures the decoded instruction from ID on every rising clock
// edge. It presents the ALU operands, the store data and the control bits to
// EX one cycle later. Operands are corrected combinationally from the
// EX/MEM and MEM/WB result buses when a younger instruction is still in
// flight. When that cannot be done, the stage asks the front end to freeze
// for one cycle.
//
// Build option:
//   FORWARD_EN  defined   -> forwarding muxes compiled in; only a true
//                            load-use dependency raises hazard_stall.
//               undefined -> ex_a/ex_store_data are the registered values;
//                            hazard_stall also covers any RAW dependency on
//                            the EX or EX/MEM destination. MEM/WB needs no
//                            check because the register file writes through.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   stall, flush          hold / squash the stage register
//   in_valid              ID holds a real instruction
//   rs_data, rt_data, imm ID operand values
//   rs_addr, rt_addr      ID source register addresses
//   rd_addr               ID destination register address
//   alu_op, use_imm       ALU operation; select imm as operand B
//   reg_write, mem_read,
//   mem_write, mem_to_reg ID control bits
//   exmem_* / memwb_*     write-back info of the two younger stages
//   ex_a, ex_b            ALU operands for EX
//   ex_store_data         data for a store (always the rt value)
//   ex_sig_op, ex_rd      captured alu_op and destination
//   ex_valid, ex_*        captured valid and control bits
//   hazard_stall          freeze PC and IF/ID for one cycle
//
// alu_op encoding: 0 pass B, 1 add, 2 sub, 3 and, 4 or, 5 not B, 6 hold, 7 slt.
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  input  logic [DATA_W-1:0]  imm,
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic [RADDR_W-1:0] rt_addr,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic [2:0]         alu_op,
  input  logic               use_imm,
  input  logic               reg_write,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               mem_to_reg,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]  exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]  memwb_result,
  output logic [DATA_W-1:0]  ex_a,
  output logic [DATA_W-1:0]  ex_b,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [2:0]         ex_sig_op,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               hazard_stall
);

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  // What the stage register does at the next edge (reset is handled in the
  // flop process itself, above all of these).
  typedef enum logic [1:0] {
    UPD_LOAD,
    UPD_BUBBLE,
    UPD_HOLD,
    UPD_FLUSH
  } upd_e;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic               valid_q,   valid_d;
  ctrl_t              ctrl_q,    ctrl_d;
  logic [2:0]         alu_op_q,  alu_op_d;
  logic               use_imm_q, use_imm_d;
  logic [RADDR_W-1:0] rd_q,      rd_d;
  logic [RADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [RADDR_W-1:0] rt_addr_q, rt_addr_d;
  logic [DATA_W-1:0]  rs_data_q, rs_data_d;
  logic [DATA_W-1:0]  rt_data_q, rt_data_d;
  logic [DATA_W-1:0]  imm_q,     imm_d;

  upd_e               upd;
  logic               rt_used;
  logic               load_use;
  logic               hazard;
  logic [DATA_W-1:0]  op_rs;
  logic [DATA_W-1:0]  op_rt;

  // ---------------------------------------------------------------------------
  // Hazard detection (uses the instruction currently in ID)
  // ---------------------------------------------------------------------------
  // rt is a real source unless the immediate replaces it, except for stores,
  // which always need rt as the store data.
  assign rt_used = ~use_imm | mem_write;

  // A load in EX has no data until MEM/WB, so even forwarding cannot help.
  assign load_use = in_valid & valid_q & ctrl_q.mem_read & (rd_q != '0) &
                    ((rd_q == rs_addr) | ((rd_q == rt_addr) & rt_used));

`ifdef FORWARD_EN
  // Youngest producer wins: EX/MEM over MEM/WB over the registered value.
  // Register 0 is hardwired zero and is never a forwarding target.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [RADDR_W-1:0] src,
    input logic [DATA_W-1:0]  reg_val,
    input logic               em_we,
    input logic [RADDR_W-1:0] em_rd,
    input logic [DATA_W-1:0]  em_res,
    input logic               mw_we,
    input logic [RADDR_W-1:0] mw_rd,
    input logic [DATA_W-1:0]  mw_res
  );
    if (src == '0)                  return reg_val;
    if (em_we && (em_rd == src))    return em_res;
    if (mw_we && (mw_rd == src))    return mw_res;
    return reg_val;
  endfunction

  assign hazard = load_use;
  assign op_rs  = fwd_sel(rs_addr_q, rs_data_q, exmem_reg_write, exmem_rd,
                          exmem_result, memwb_reg_write, memwb_rd, memwb_result);
  assign op_rt  = fwd_sel(rt_addr_q, rt_data_q, exmem_reg_write, exmem_rd,
                          exmem_result, memwb_reg_write, memwb_rd, memwb_result);
`else
  logic ex_raw;
  logic mem_raw;
  logic unused_fwd;

  // Without bypass paths, any pending write to a source in EX or EX/MEM has to
  // drain before ID may issue. MEM/WB is covered by register-file write-through.
  assign ex_raw  = valid_q & ctrl_q.reg_write & (rd_q != '0) &
                   ((rd_q == rs_addr) | ((rd_q == rt_addr) & rt_used));
  assign mem_raw = exmem_reg_write & (exmem_rd != '0) &
                   ((exmem_rd == rs_addr) | ((exmem_rd == rt_addr) & rt_used));

  assign hazard  = load_use | (in_valid & (ex_raw | mem_raw));
  assign op_rs   = rs_data_q;
  assign op_rt   = rt_data_q;

  // Forwarding inputs and captured source addresses have no use in this build.
  assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result,
                        rs_addr_q, rt_addr_q};
`endif

  assign hazard_stall = hazard;

  // ---------------------------------------------------------------------------
  // Edge-update selection: flush > stall > bubble > load
  // ---------------------------------------------------------------------------
  always_comb begin
    if (flush)       upd = UPD_FLUSH;
    else if (stall)  upd = UPD_HOLD;
    else if (hazard) upd = UPD_BUBBLE;
    else             upd = UPD_LOAD;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a hold default first, so no path can leave a
    // variable unassigned and infer a latch.
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    alu_op_d  = alu_op_q;
    use_imm_d = use_imm_q;
    rd_d      = rd_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;

    unique case (upd)
      // Squash and bubble only kill valid and controls; the operand fields
      // are meaningless once valid is low, so they simply keep their value.
      UPD_FLUSH, UPD_BUBBLE: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
      UPD_HOLD: begin
      end
      UPD_LOAD: begin
        valid_d   = in_valid;
        // An empty ID slot must never write anything downstream.
        ctrl_d    = in_valid ? ctrl_t'{reg_write, mem_read, mem_write, mem_to_reg}
                             : ctrl_t'('0);
        alu_op_d  = alu_op;
        use_imm_d = use_imm;
        rd_d      = rd_addr;
        rs_addr_d = rs_addr;
        rt_addr_d = rt_addr;
        rs_data_d = rs_data;
        rt_data_d = rt_data;
        imm_d     = imm;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data fields are clocked flops, not a memory array. They are
      // cleared with everything else so no fragment of an interrupted
      // instruction survives a reset.
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      alu_op_q  <= '0;
      use_imm_q <= 1'b0;
      rd_q      <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      alu_op_q  <= alu_op_d;
      use_imm_q <= use_imm_d;
      rd_q      <= rd_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ex_a          = op_rs;
  assign ex_b          = use_imm_q ? imm_q : op_rt;
  assign ex_store_data = op_rt;
  assign ex_sig_op     = alu_op_q;
  assign ex_rd         = rd_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage -- self-checking bench for id_ex_stage.
// A table of directed rows walks reset, immediate/store, flush-versus-stall
// priority, the zero register, load-use and forwarding priority. A randomized
// run follows and is compared against a behavioural model of the stage.
// Expectations follow the FORWARD_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DW = 16;
  localparam int AW = 3;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          rst_n, stall, flush, in_valid;
  logic [DW-1:0] rs_data, rt_data, imm;
  logic [AW-1:0] rs_addr, rt_addr, rd_addr;
  logic [2:0]    alu_op;
  logic          use_imm, reg_write, mem_read, mem_write, mem_to_reg;
  logic          exmem_reg_write, memwb_reg_write;
  logic [AW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;
  logic [DW-1:0] ex_a, ex_b, ex_store_data;
  logic [2:0]    ex_sig_op;
  logic [AW-1:0] ex_rd;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic          hazard_stall;

  id_ex_stage #(.DATA_W(DW), .RADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .alu_op(alu_op), .use_imm(use_imm), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_sig_op(ex_sig_op), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .hazard_stall(hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          rst_n, stall, flush, in_valid;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic [AW-1:0] rs_addr, rt_addr, rd_addr;
    logic [2:0]    alu_op;
    logic          use_imm, reg_write, mem_read, mem_write, mem_to_reg;
    logic          exmem_we;
    logic [AW-1:0] exmem_rd;
    logic [DW-1:0] exmem_res;
    logic          memwb_we;
    logic [AW-1:0] memwb_rd;
    logic [DW-1:0] memwb_res;
  } stim_t;

  // Model of the instruction sitting in EX; 'known' is low when its operand
  // fields are don't-care (after a flush or bubble).
  typedef struct packed {
    logic          valid;
    logic [3:0]    ctl;      // {reg_write, mem_read, mem_write, mem_to_reg}
    logic          known;
    logic [2:0]    op;
    logic          use_imm;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] rs_d, rt_d, imm;
  } ex_m_t;

  typedef struct {
    stim_t         s;
    bit            chk;
    bit            ev;
    bit [3:0]      ectl;
    bit            eh;
    bit            ckd;
    bit [2:0]      eop;
    bit [AW-1:0]   erd;
    bit [DW-1:0]   ea, eb, esd;
  } row_t;

  row_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst_n = s.rst_n; stall = s.stall; flush = s.flush; in_valid = s.in_valid;
    rs_data = s.rs_data; rt_data = s.rt_data; imm = s.imm;
    rs_addr = s.rs_addr; rt_addr = s.rt_addr; rd_addr = s.rd_addr;
    alu_op = s.alu_op; use_imm = s.use_imm; reg_write = s.reg_write;
    mem_read = s.mem_read; mem_write = s.mem_write; mem_to_reg = s.mem_to_reg;
    exmem_reg_write = s.exmem_we; exmem_rd = s.exmem_rd; exmem_result = s.exmem_res;
    memwb_reg_write = s.memwb_we; memwb_rd = s.memwb_rd; memwb_result = s.memwb_res;
  endtask

  task automatic add_row(input stim_t s, input bit chk, input bit ev, input bit [3:0] ectl,
                         input bit eh, input bit ckd, input bit [2:0] eop,
                         input bit [AW-1:0] erd, input bit [DW-1:0] ea,
                         input bit [DW-1:0] eb, input bit [DW-1:0] esd);
    row_t r;
    r.s = s; r.chk = chk; r.ev = ev; r.ectl = ectl; r.eh = eh; r.ckd = ckd;
    r.eop = eop; r.erd = erd; r.ea = ea; r.eb = eb; r.esd = esd;
    tbl.push_back(r);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  // Value a consumer of register 'a' sees: the newest in-flight write, else
  // the value read in ID. Register 0 always reads as what the file gave.
  function automatic logic [DW-1:0] model_operand(input logic [AW-1:0] a,
                                                  input logic [DW-1:0] regv,
                                                  input stim_t s);
    if (!FWD || a == 0) return regv;
    if (s.exmem_we && s.exmem_rd == a) return s.exmem_res;
    if (s.memwb_we && s.memwb_rd == a) return s.memwb_res;
    return regv;
  endfunction

  // ID must wait when one of its sources is produced by an instruction whose
  // result is not yet obtainable.
  function automatic bit model_hazard(input ex_m_t m, input stim_t s);
    logic [AW-1:0] srcs[$];
    logic [AW-1:0] blockers[$];
    if (!s.in_valid) return 1'b0;
    srcs.push_back(s.rs_addr);
    if (!s.use_imm || s.mem_write) srcs.push_back(s.rt_addr);
    if (m.valid && m.ctl[2] && m.rd != 0) blockers.push_back(m.rd);
    if (!FWD) begin
      if (m.valid && m.ctl[3] && m.rd != 0) blockers.push_back(m.rd);
      if (s.exmem_we && s.exmem_rd != 0)    blockers.push_back(s.exmem_rd);
    end
    foreach (blockers[i])
      foreach (srcs[j])
        if (blockers[i] == srcs[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ex_m_t model_step(input ex_m_t m, input stim_t s);
    ex_m_t n;
    n = m;
    if (!s.rst_n) begin
      n = '0;
      n.known = 1'b1;
    end else if (s.flush || (!s.stall && model_hazard(m, s))) begin
      n.valid = 1'b0;
      n.ctl   = '0;
      n.known = 1'b0;
    end else if (!s.stall) begin
      n.valid   = s.in_valid;
      n.ctl     = s.in_valid ? {s.reg_write, s.mem_read, s.mem_write, s.mem_to_reg} : 4'b0;
      n.known   = 1'b1;
      n.op      = s.alu_op;
      n.use_imm = s.use_imm;
      n.rs      = s.rs_addr;
      n.rt      = s.rt_addr;
      n.rd      = s.rd_addr;
      n.rs_d    = s.rs_data;
      n.rt_d    = s.rt_data;
      n.imm     = s.imm;
    end
    return n;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst_n      = ($urandom_range(0, 63) != 0);
    s.stall      = ($urandom_range(0, 7) == 0);
    s.flush      = ($urandom_range(0, 15) == 0);
    s.in_valid   = ($urandom_range(0, 3) != 0);
    s.rs_data    = DW'($urandom);
    s.rt_data    = DW'($urandom);
    s.imm        = DW'($urandom);
    s.rs_addr    = AW'($urandom_range(0, 3));
    s.rt_addr    = AW'($urandom_range(0, 3));
    s.rd_addr    = AW'($urandom_range(0, 3));
    s.alu_op     = 3'($urandom_range(0, 7));
    s.use_imm    = 1'($urandom_range(0, 1));
    s.reg_write  = 1'($urandom_range(0, 1));
    s.mem_read   = 1'($urandom_range(0, 1));
    s.mem_write  = 1'($urandom_range(0, 1));
    s.mem_to_reg = 1'($urandom_range(0, 1));
    s.exmem_we   = 1'($urandom_range(0, 1));
    s.exmem_rd   = AW'($urandom_range(0, 3));
    s.exmem_res  = DW'($urandom);
    s.memwb_we   = 1'($urandom_range(0, 1));
    s.memwb_rd   = AW'($urandom_range(0, 3));
    s.memwb_res  = DW'($urandom);
    return s;
  endfunction

  function automatic logic [3:0] dut_ctl();
    return {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
  endfunction

  task automatic compare_model(input ex_m_t m, input stim_t s, input int cyc);
    logic [DW-1:0] exp_rt;
    exp_rt = model_operand(m.rt, m.rt_d, s);
    check($sformatf("rnd%0d ex_valid", cyc), 32'(ex_valid), 32'(m.valid));
    check($sformatf("rnd%0d ctrl", cyc), 32'(dut_ctl()), 32'(m.ctl));
    check($sformatf("rnd%0d hazard_stall", cyc), 32'(hazard_stall), 32'(model_hazard(m, s)));
    if (m.known) begin
      check($sformatf("rnd%0d ex_sig_op", cyc), 32'(ex_sig_op), 32'(m.op));
      check($sformatf("rnd%0d ex_rd", cyc), 32'(ex_rd), 32'(m.rd));
      check($sformatf("rnd%0d ex_a", cyc), 32'(ex_a), 32'(model_operand(m.rs, m.rs_d, s)));
      check($sformatf("rnd%0d ex_b", cyc), 32'(ex_b), 32'(m.use_imm ? m.imm : exp_rt));
      check($sformatf("rnd%0d ex_store_data", cyc), 32'(ex_store_data), 32'(exp_rt));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    stim_t s;
    ex_m_t m;

    // Each row: inputs driven for one cycle; expectations are the outputs seen
    // with those inputs applied, before the edge that consumes them.

    // Reset while stalled, then reset state.
    s = idle(); s.rst_n = 0; s.stall = 1; s.in_valid = 1; s.rs_addr = 3; s.rs_data = 16'h1234; s.reg_write = 1;
    add_row(s, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    s = idle();
    add_row(s, 1, 0, 4'b0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    // Store with immediate: B is imm, store data is the forwarded rt.
    s = idle(); s.in_valid = 1; s.alu_op = 1; s.rs_addr = 1; s.rs_data = 16'h0010;
    s.rt_addr = 4; s.rt_data = 16'h0033; s.imm = 16'h0007; s.use_imm = 1; s.mem_write = 1;
    add_row(s, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    s = idle(); s.stall = 1; s.exmem_we = 1; s.exmem_rd = 4; s.exmem_res = 16'h00AA;
    add_row(s, 1, 1, 4'b0010, 0, 1, 1, 0, 16'h0010, 16'h0007, FWD ? 16'h00AA : 16'h0033);
    // Flush together with stall: flush wins.
    s = idle(); s.flush = 1; s.stall = 1; s.in_valid = 1; s.reg_write = 1; s.rd_addr = 2;
    add_row(s, 1, 1, 4'b0010, 0, 1, 1, 0, 16'h0010, 16'h0007, 16'h0033);
    s = idle(); s.in_valid = 1; s.imm = 16'h0005; s.use_imm = 1; s.rs_addr = 5; s.rs_data = 16'h0021;
    s.rt_addr = 6; s.rt_data = 16'h0042; s.reg_write = 1; s.rd_addr = 7; s.alu_op = 2;
    add_row(s, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    // Stall alone holds the captured instruction for three edges.
    s = idle(); s.stall = 1; s.in_valid = 1; s.imm = 16'h0999; s.rs_data = 16'hDEAD; s.rd_addr = 1; s.reg_write = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin s.stall = 0; s.in_valid = 0; end
      add_row(s, 1, 1, 4'b1000, 0, 1, 2, 7, 16'h0021, 16'h0005, 16'h0042);
    end
    // Zero register never forwards.
    s = idle(); s.in_valid = 1; s.rt_data = 16'h0003; s.reg_write = 1; s.rd_addr = 2; s.alu_op = 1;
    add_row(s, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    s = idle(); s.exmem_we = 1; s.exmem_res = 16'hFFFF; s.memwb_we = 1; s.memwb_res = 16'hEEEE;
    add_row(s, 1, 1, 4'b1000, 0, 1, 1, 2, 16'h0000, 16'h0003, 16'h0003);
    // Load-use: load r3, then add using r3.
    s = idle(); s.in_valid = 1; s.mem_read = 1; s.reg_write = 1; s.mem_to_reg = 1; s.rd_addr = 3;
    s.rs_addr = 1; s.rs_data = 16'h0100; s.imm = 16'h0004; s.use_imm = 1; s.alu_op = 1;
    add_row(s, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    s = idle(); s.in_valid = 1; s.rs_addr = 3; s.rt_addr = 4; s.rt_data = 16'h0009;
    s.reg_write = 1; s.rd_addr = 5; s.alu_op = 1;
    add_row(s, 1, 1, 4'b1101, 1, 1, 1, 3, 16'h0100, 16'h0004, 16'h0000);
    s.exmem_we = 1; s.exmem_rd = 3; s.exmem_res = 16'h0104;
    add_row(s, 1, 0, 4'b0000, !FWD, 0, 0, 0, 0, 0, 0);
    s.exmem_we = 0; s.rs_data = 16'h7777; s.memwb_we = 1; s.memwb_rd = 3; s.memwb_res = 16'h7777;
    add_row(s, 1, FWD, FWD ? 4'b1000 : 4'b0000, 0, FWD, 1, 5, 16'h7777, 16'h0009, 16'h0009);
    s = idle();
    add_row(s, 1, 1, 4'b1000, 0, 1, 1, 5, 16'h7777, 16'h0009, 16'h0009);
    // Forwarding priority: EX/MEM over MEM/WB.
    s = idle(); s.in_valid = 1; s.rs_addr = 2; s.rs_data = 16'h0BBB; s.alu_op = 1; s.reg_write = 1; s.rd_addr = 1;
    add_row(s, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    s = idle(); s.stall = 1; s.exmem_we = 1; s.exmem_rd = 2; s.exmem_res = 16'h1111;
    s.memwb_we = 1; s.memwb_rd = 2; s.memwb_res = 16'h2222;
    add_row(s, 1, 1, 4'b1000, 0, 1, 1, 1, FWD ? 16'h1111 : 16'h0BBB, 16'h0000, 16'h0000);
    s.exmem_we = 0;
    add_row(s, 1, 1, 4'b1000, 0, 1, 1, 1, FWD ? 16'h2222 : 16'h0BBB, 16'h0000, 16'h0000);
    // Mid-operation reset discards the held instruction.
    s = idle(); s.rst_n = 0; s.stall = 1;
    add_row(s, 1, 1, 4'b1000, 0, 1, 1, 1, 16'h0BBB, 16'h0000, 16'h0000);
    s = idle(); s.stall = 1;
    add_row(s, 1, 0, 4'b0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].s);
      #1;
      if (tbl[i].chk) begin
        check($sformatf("row%0d ex_valid", i), 32'(ex_valid), 32'(tbl[i].ev));
        check($sformatf("row%0d ctrl", i), 32'(dut_ctl()), 32'(tbl[i].ectl));
        check($sformatf("row%0d hazard_stall", i), 32'(hazard_stall), 32'(tbl[i].eh));
        if (tbl[i].ckd) begin
          check($sformatf("row%0d ex_sig_op", i), 32'(ex_sig_op), 32'(tbl[i].eop));
          check($sformatf("row%0d ex_rd", i), 32'(ex_rd), 32'(tbl[i].erd));
          check($sformatf("row%0d ex_a", i), 32'(ex_a), 32'(tbl[i].ea));
          check($sformatf("row%0d ex_b", i), 32'(ex_b), 32'(tbl[i].eb));
          check($sformatf("row%0d ex_store_data", i), 32'(ex_store_data), 32'(tbl[i].esd));
        end
      end
    end

    // Randomized run against the model, starting from a known reset.
    @(negedge clk);
    s = idle(); s.rst_n = 0;
    drive(s);
    m = '0;
    @(posedge clk);
    m = model_step(m, s);
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      s = rand_stim();
      drive(s);
      #1;
      compare_model(m, s, c);
      @(posedge clk);
      m = model_step(m, s);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width.
REQ-002 SHALL have parameter RADDR_W, default 3, register-address width.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have inputs stall(1), flush(1), in_valid(1): hold, squash and ID-instruction-valid controls.
REQ-006 SHALL have inputs rs_data, rt_data, imm (DATA_W each) and rs_addr, rt_addr, rd_addr (RADDR_W each).
REQ-007 SHALL have inputs alu_op(3), use_imm(1), reg_write(1), mem_read(1), mem_write(1), mem_to_reg(1).
REQ-008 SHALL have forwarding inputs exmem_reg_write(1), exmem_rd(RADDR_W), exmem_result(DATA_W), memwb_reg_write(1), memwb_rd(RADDR_W), memwb_result(DATA_W).
REQ-009 SHALL have outputs ex_a, ex_b, ex_store_data (DATA_W): ALU operands A and B, and store data.
REQ-010 SHALL have outputs ex_sig_op(3), ex_rd(RADDR_W), ex_valid(1), ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg (1 each).
REQ-011 SHALL have output hazard_stall(1), a request to freeze PC and IF/ID for one cycle.

Function
REQ-012 SHALL register all ID inputs into stage registers on each clock edge; capture latency one cycle.
REQ-013 SHALL apply edge-update priority: reset > flush > stall > bubble > load.
REQ-014 flush SHALL clear ex_valid and all control outputs next cycle; data registers don't-care.
REQ-015 stall SHALL hold every stage register unchanged, including when hazard_stall is asserted.
REQ-016 bubble (hazard_stall=1, stall=0, flush=0) SHALL load ex_valid=0 and zero all controls.
REQ-017 load SHALL capture inputs with ex_valid=in_valid; if in_valid=0, controls are captured as zero.
REQ-018 ex_sig_op SHALL equal the captured alu_op (0 pass B, 1 add, 2 sub, 3 and, 4 or, 5 not B, 6 hold, 7 slt).
REQ-019 ex_b SHALL be the captured imm when captured use_imm=1, else the forwarded rt value.
REQ-020 ex_a SHALL be the forwarded rs value; ex_store_data SHALL always be the forwarded rt value.
REQ-021 Forwarding SHALL be combinational from the registered address; EX/MEM match wins over MEM/WB match, otherwise the registered value is used.
REQ-022 Address 0 SHALL never match; it is hardwired zero.
REQ-023 A match SHALL require the corresponding *_reg_write=1 and the address equal to the captured source.
REQ-024 hazard_stall SHALL be combinational: in_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==rs_addr | (ex_rd==rt_addr & (!use_imm | mem_write))).
REQ-025 After one bubble, the dependency SHALL resolve via MEM/WB forwarding with no second bubble.

Reset
REQ-026 rst_n=0 at an edge SHALL clear ex_valid, all controls, ex_sig_op, ex_rd and all data registers to 0.
REQ-027 Reset SHALL override stall and flush; hazard_stall SHALL read 0 the cycle after reset.
REQ-028 Mid-operation reset SHALL discard the held instruction; no partial state survives.

Configuration
REQ-029 Macro FORWARD_EN defined SHALL compile in the forwarding muxes per REQ-021..025.
REQ-030 Without FORWARD_EN: ex_a and ex_store_data are the registered values, and ex_b is imm or registered rt.
REQ-031 Without FORWARD_EN, hazard_stall SHALL also assert on an in_valid source match (rt only when it is used) against a valid reg_write ex_rd, or against exmem_rd with exmem_reg_write, address 0 excluded.
REQ-032 Without FORWARD_EN, the register file provides MEM/WB write-through; no MEM/WB check is needed.

Verification
REQ-033 Reset: rst_n=0 with stall=1 -> next cycle ex_valid=0, ex_a=0, ex_b=0, hazard_stall=0.
REQ-034 Forward priority (FORWARD_EN): captured rs=2, exmem_rd=2 (result 0x1111), memwb_rd=2 (result 0x2222) -> ex_a=0x1111; exmem_reg_write=0 -> 0x2222.
REQ-035 Load-use: ex holds a load with rd=3; ID add with rs=3 -> hazard_stall=1, next ex_valid=0; the cycle after, add captured and ex_a=memwb_result.
REQ-036 Zero register: captured rs=0, exmem_rd=0 with write=1, exmem_result=0xFFFF -> ex_a=registered rs_data (0).
REQ-037 Priority: flush=1 and stall=1 together -> ex_valid=0; stall=1 alone with in_valid=1, imm=0x0005 -> outputs unchanged for 3 cycles.
REQ-038 Immediate: use_imm=1, imm=0x0007, rt forwarded 0x00AA, mem_write=1 -> ex_b=0x0007, ex_store_data=0x00AA.
